seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter WIDTH, default 4, meaning pattern length in bits; legal range 2..16.
REQ-002 Parameter CNT_W, default 8, meaning match-counter width in bits; legal range 1..16.
REQ-003 clk  input  1  meaning the single clock; all state is updated on its rising edge.
REQ-004 reset  input  1  meaning asynchronous, active-low reset.
REQ-005 in_valid  input  1  meaning the serial bit on `in` is sampled this cycle.
REQ-006 in  input  1  meaning the serial data bit.
REQ-007 pattern  input  WIDTH  meaning the target sequence; pattern[WIDTH-1] is the first (oldest) bit.
REQ-008 overlap  input  1  meaning 1 = overlapping detection, 0 = non-overlapping detection.
REQ-009 clear  input  1  meaning synchronous flush of history, fill count, dec and match_count.
REQ-010 dec  output  1  meaning a registered one-cycle match pulse.
REQ-011 match_count  output  CNT_W  meaning a registered, saturating count of detected matches.

Function
REQ-012 The block SHALL hold a WIDTH-bit history shift register and a fill counter of ceil(log2(WIDTH+1)) bits that saturates at WIDTH.
REQ-013 At an edge with in_valid=1 and clear=0, the next history SHALL be {history[WIDTH-2:0], in} and fill SHALL increment, saturating at WIDTH.
REQ-014 A match SHALL be defined as: in_valid=1, clear=0, fill >= WIDTH-1 before the edge, and {history[WIDTH-2:0], in} == pattern, evaluated with the pattern value present at that edge.
REQ-015 dec SHALL be 1 for exactly the one cycle following the matching edge (latency 1 clock from the sampled final bit), and 0 otherwise.
REQ-016 No match SHALL be reported before WIDTH valid bits have been received since reset, clear, or a non-overlap match, regardless of stale history contents, including all-zero patterns.
REQ-017 When overlap=1 on a match, fill SHALL remain WIDTH, so trailing bits can start the next match.
REQ-018 When overlap=0 on a match, fill SHALL be set to 0, so the next match needs WIDTH fresh valid bits.
REQ-019 overlap SHALL be sampled at the matching edge only; changing it mid-stream SHALL NOT alter history.
REQ-020 On a match, match_count SHALL increment by 1 and saturate at 2^CNT_W-1 with no wrap.
REQ-021 When in_valid=0 and clear=0, history, fill and match_count SHALL hold and dec SHALL be 0 the next cycle.
REQ-022 clear=1 SHALL zero history, fill, match_count and dec at the edge, with priority over in_valid; the bit presented that cycle SHALL be discarded.
REQ-023 Back-to-back matches on consecutive edges (e.g. an all-ones pattern with overlap=1) SHALL hold dec high continuously, one count per edge.

Reset
REQ-024 reset=0 SHALL immediately, without waiting for clk, force history=0, fill=0, dec=0 and match_count=0.
REQ-025 Reset deassertion SHALL be synchronised internally, so the first sampled bit is taken no earlier than the second rising edge after reset rises.
REQ-026 Reset asserted mid-pattern SHALL discard the partial sequence; no match SHALL complete from bits received before reset.

Verification
REQ-027 WIDTH=4, pattern=1101, overlap=1, valid stream 1,1,0,1,1,0,1 -> dec pulses after the 4th and 7th bits; match_count=2.
REQ-028 Same stream with overlap=0 -> dec pulses after the 4th bit only; match_count=1.
REQ-029 pattern=0000, after reset -> three valid 0s give no dec; the fourth 0 gives dec=1 for one cycle.
REQ-030 pattern=1101; stream 1,1, then in_valid=0 for 3 cycles, then 0,1 -> dec stays 0 during the gap and pulses once after the final 1.
REQ-031 CNT_W=2, pattern=1111, overlap=1, eight valid 1s -> dec high for 5 consecutive cycles; match_count saturates at 3.
REQ-032 clear=1 and in_valid=1 coinciding with a would-be final matching bit -> no dec, match_count=0; reset=0 asserted between clock edges -> outputs 0 before the next edge.

Source files
------------

// File: rtl/seq_detect_param_if.sv
// Bundle of the serial-input / detector-output signals of seq_detect_param.
//   master : drives in_valid, in, pattern, overlap, clear; observes dec, match_count
//   slave  : the detector side (inputs above, drives dec and match_count)
`timescale 1ns / 1ps

interface seq_detect_param_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in;
  logic [WIDTH-1:0] pattern;
  logic             overlap;
  logic             clear;
  logic             dec;
  logic [CNT_W-1:0] match_count;

  modport master (
    output in_valid,
    output in,
    output pattern,
    output overlap,
    output clear,
    input  dec,
    input  match_count
  );

  modport slave (
    input  in_valid,
    input  in,
    input  pattern,
    input  overlap,
    input  clear,
    output dec,
    output match_count
  );
endinterface

// File: rtl/seq_detect_param.sv
// Serial pattern detector with selectable overlapping / non-overlapping detection.
// Ports:
//   clk    - single clock, rising edge
//   reset  - asynchronous active-low reset (deassertion synchronised internally)
//   bus    - seq_detect_param_if.slave: in_valid/in serial input, pattern (MSB is the
//            oldest bit), overlap mode, synchronous clear; dec one-cycle match pulse
//            and saturating match_count outputs, both registered.
`timescale 1ns / 1ps

module seq_detect_param #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  seq_detect_param_if.slave   bus
);

  localparam int unsigned FILL_W = $clog2(WIDTH + 1);
  localparam logic [FILL_W-1:0] FillFull = FILL_W'(WIDTH);
  localparam logic [FILL_W-1:0] FillLast = FILL_W'(WIDTH - 1);

  logic [1:0]        rst_sync_q;
  logic              run;

  logic [WIDTH-1:0]  history_q, history_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              dec_q, dec_d;

  logic [WIDTH-1:0]  shift_in;
  logic              take;
  logic              match;

  // Assertion is immediate; release only enables sampling two edges later, so a
  // bit presented around the reset-release edge is never taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run = rst_sync_q[1];

  always_comb begin
    shift_in  = {history_q[WIDTH-2:0], bus.in};
    take      = run && bus.in_valid && !bus.clear;
    // The fill gate stops stale history (or an all-zero reset history) from
    // matching before WIDTH fresh bits have arrived.
    match     = take && (fill_q >= FillLast) && (shift_in == bus.pattern);

    history_d = history_q;
    fill_d    = fill_q;
    count_d   = count_q;
    dec_d     = match;

    if (bus.clear) begin
      history_d = '0;
      fill_d    = '0;
      count_d   = '0;
    end else if (take) begin
      history_d = shift_in;
      if (match) begin
        // Overlap keeps the tail as a prefix of the next match; otherwise the
        // next match needs a full WIDTH fresh bits.
        fill_d = bus.overlap ? FillFull : '0;
        if (count_q != {CNT_W{1'b1}}) begin
          count_d = count_q + CNT_W'(1);
        end
      end else if (fill_q != FillFull) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      history_q <= '0;
      fill_q    <= '0;
      count_q   <= '0;
      dec_q     <= 1'b0;
    end else begin
      history_q <= history_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
      dec_q     <= dec_d;
    end
  end

  assign bus.dec         = dec_q;
  assign bus.match_count = count_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: two instances (CNT_W=8 and CNT_W=2) share one
// stimulus stream; a queue-based reference model predicts dec and match_count per edge.
`timescale 1ns / 1ps

module tb_seq_detect_param;

  localparam int W = 4;

  typedef struct {
    bit dec;
    int cnt;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         bit_in;
  logic [W-1:0] pat;
  logic         ov;
  logic         clr;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  // Reference model: bits received since the last reset/clear/non-overlap match.
  bit   hist[$];
  int   m_cnt;

  always #5 clk = ~clk;

  seq_detect_param_if #(.WIDTH(W), .CNT_W(8)) bus_a ();
  seq_detect_param_if #(.WIDTH(W), .CNT_W(2)) bus_b ();

  assign bus_a.in_valid = in_valid;
  assign bus_a.in       = bit_in;
  assign bus_a.pattern  = pat;
  assign bus_a.overlap  = ov;
  assign bus_a.clear    = clr;
  assign bus_b.in_valid = in_valid;
  assign bus_b.in       = bit_in;
  assign bus_b.pattern  = pat;
  assign bus_b.overlap  = ov;
  assign bus_b.clear    = clr;

  seq_detect_param #(.WIDTH(W), .CNT_W(8)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  seq_detect_param #(.WIDTH(W), .CNT_W(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  function automatic int sat(int x, int m);
    return (x > m) ? m : x;
  endfunction

  task automatic check(string name, longint act, longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus and push the predicted post-edge outputs.
  task automatic step(bit v, bit b, bit c, bit o);
    exp_t e;
    bit   hit;
    @(negedge clk);
    in_valid = v;
    bit_in   = b;
    clr      = c;
    ov       = o;
    e.dec    = 1'b0;
    if (c) begin
      hist.delete();
      m_cnt = 0;
    end else if (v) begin
      hist.push_back(b);
      if (hist.size() > W) void'(hist.pop_front());
      hit = (hist.size() == W);
      for (int i = 0; i < W; i++) begin
        if (hist.size() == W && hist[i] != pat[W-1-i]) hit = 1'b0;
      end
      if (hit) begin
        e.dec = 1'b1;
        m_cnt++;
        if (!o) hist.delete();
      end
    end
    e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic feed(input bit [15:0] bits, input int n, input bit o);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, o);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset asserted between edges; outputs must drop before the next edge.
  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    clr      = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("async_rst_dec", bus_a.dec, 0);
    check("async_rst_cnt", bus_a.match_count, 0);
    hist.delete();
    m_cnt = 0;
    @(negedge clk);
    reset = 1'b1;
    idle(3);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: the DUT presents registered outputs after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_dec_a", bus_a.dec, e.dec);
        check("sb_cnt_a", bus_a.match_count, sat(e.cnt, 255));
        check("sb_dec_b", bus_b.dec, e.dec);
        check("sb_cnt_b", bus_b.match_count, sat(e.cnt, 3));
      end
    end
  end

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    bit_in   = 1'b0;
    clr      = 1'b0;
    ov       = 1'b0;
    pat      = 4'b1101;
    m_cnt    = 0;
    #1;
    check("reset_dec", bus_a.dec, 0);
    check("reset_cnt", bus_a.match_count, 0);
    @(negedge clk);
    reset = 1'b1;
    idle(3);

    // Overlapping detection: matches after bits 4 and 7.
    pat = 4'b1101;
    feed(16'b1101101, 7, 1'b1);
    settle();
    check("ovl_count", bus_a.match_count, 2);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Non-overlapping: only the first match.
    feed(16'b1101101, 7, 1'b0);
    settle();
    check("novl_count", bus_a.match_count, 1);

    // All-zero pattern after reset needs four real zeros.
    do_reset();
    pat = 4'b0000;
    feed(16'b000, 3, 1'b1);
    settle();
    check("zero_pat_early", bus_a.dec, 0);
    feed(16'b0, 1, 1'b1);
    settle();
    check("zero_pat_hit", bus_a.dec, 1);
    idle(1);
    settle();
    check("zero_pat_pulse", bus_a.dec, 0);

    // Gap in in_valid holds state.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    pat = 4'b1101;
    feed(16'b11, 2, 1'b1);
    idle(3);
    feed(16'b01, 2, 1'b1);
    settle();
    check("gap_dec", bus_a.dec, 1);
    check("gap_count", bus_a.match_count, 1);

    // Back-to-back matches and saturation of the 2-bit counter.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    pat = 4'b1111;
    feed(16'hff, 8, 1'b1);
    settle();
    check("b2b_cnt_a", bus_a.match_count, 5);
    check("b2b_cnt_b_sat", bus_b.match_count, 3);

    // Clear coinciding with the final matching bit wins.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    pat = 4'b1101;
    feed(16'b110, 3, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    settle();
    check("clr_final_dec", bus_a.dec, 0);
    check("clr_final_cnt", bus_a.match_count, 0);

    // Reset mid-pattern discards the partial sequence.
    feed(16'b110, 3, 1'b1);
    do_reset();
    feed(16'b1, 1, 1'b1);
    settle();
    check("rst_mid_dec", bus_a.dec, 0);

    // Randomised traffic, with occasional pattern changes, clears and a reset.
    pat = 4'($urandom);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) pat = 4'($urandom);
      if (i == 1500) do_reset();
      step(($urandom_range(3) != 0), 1'($urandom), ($urandom_range(79) == 0), 1'($urandom));
    end

    idle(2);
    settle();
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
